// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetch stage for the IDIOT processor.
// Issues sequential reads over a req/ack memory handshake, buffers the
// returned {word, pc} pairs in a small FIFO and hands them to the IR path
// over valid/ready. A redirect flushes the FIFO and restarts fetching.
// Optional feature macro: FETCH_STALL_COUNT_EN (consumer-starvation counter).
module fetch_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic [WIDTH-1:0] ir_out,
    output logic [WIDTH-1:0] ir_pc,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [15:0]      stall_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [WIDTH-1:0] PC_ONE    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_after_push;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] pc_q   [DEPTH];
    logic [DEPTH-1:0] wr_en;

    // A redirect flushes the head, so a same-cycle pop is meaningless.
    assign pop      = ir_valid && ir_ready && !redirect;
    assign ir_valid = (count_q != '0);
    assign mem_req  = (state_q != ST_IDLE);
    assign mem_addr = mem_addr_q;
    assign ir_out   = word_q[rd_ptr_q];
    assign ir_pc    = pc_q[rd_ptr_q];

    // Per-entry write strobes for the FIFO storage.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_wr_en
        assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
    end

    // Request FSM: a request is only issued when a FIFO slot is guaranteed.
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        mem_addr_d       = mem_addr_q;
        push             = 1'b0;
        count_after_push = count_q + CNT_ONE - (pop ? CNT_ONE : '0);
        case (state_q)
            ST_IDLE: begin
                // Late acks from an abandoned request are ignored here.
                if (!redirect && (count_q < DEPTH_CNT)) begin
                    state_d    = ST_REQ;
                    mem_addr_d = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    // With a same-cycle ack the data is simply not pushed.
                    state_d = mem_ack ? ST_IDLE : ST_DROP;
                end else if (mem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_ONE;
                    if (count_after_push < DEPTH_CNT) begin
                        mem_addr_d = fetch_pc_q + PC_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                // Outstanding request must complete before a new one starts.
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
    end

    // FIFO occupancy and pointer bookkeeping; redirect empties the FIFO.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            mem_addr_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so ir_out/ir_pc start at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    word_q[i] <= mem_rdata;
                    pc_q[i]   <= mem_addr_q;
                end
            end
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_count_q, stall_count_d;

    // Count cycles where the consumer wants a word but none is available.
    always_comb begin
        stall_count_d = stall_count_q;
        if (ir_ready && !ir_valid && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Starvation counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit with a
// behavioural memory (data = addr ^ 0xA500, programmable wait cycles).
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_out;
    logic [15:0] ir_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] stall_count;

`ifdef FETCH_STALL_COUNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;
    int wait_cnt = 0;
    bit force_ack = 1'b0;

    fetch_unit #(.WIDTH(16), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_out     (ir_out),
        .ir_pc      (ir_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ready;
        bit          exp_req;
        logic [15:0] exp_addr;
        bit          exp_valid;
        logic [15:0] exp_pc;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit rdy, bit req, logic [15:0] addr,
                                bit vld, logic [15:0] pc, logic [15:0] out);
        vec_t v;
        v.rst = rst; v.ready = rdy; v.exp_req = req; v.exp_addr = addr;
        v.exp_valid = vld; v.exp_pc = pc; v.exp_out = out;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: memory model drives ack/data at negedge, state advances at posedge.
    task automatic step();
        bit req_s;
        bit ack_s;
        @(negedge clk);
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hDEAD;
        end else if (mem_req && (wait_cnt >= lat)) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_addr ^ 16'hA500;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'h0000;
        end
        req_s = mem_req;
        ack_s = mem_ack;
        @(posedge clk);
        #1;
        if (req_s && !ack_s) wait_cnt++;
        else wait_cnt = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        step();
        step();
        chk("rst mem_req", 16'(mem_req), 16'h0);
        chk("rst mem_addr", mem_addr, 16'h0);
        chk("rst ir_valid", 16'(ir_valid), 16'h0);
        chk("rst ir_out", ir_out, 16'h0);
        chk("rst ir_pc", ir_pc, 16'h0);
        chk("rst stall_count", stall_count, 16'h0);
        reset    = 1'b0;
        wait_cnt = 0;
        $display("reset applied");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0; reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0;
        ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;

        // Streaming, 0-wait memory, consumer always ready.
        add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        add(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        add(1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0000, 16'hA500);
        add(1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0001, 16'hA501);
        add(1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0002, 16'hA502);
        add(1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0003, 16'hA503);
        add(1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 16'h0004, 16'hA504);
        // Consumer blocked: FIFO fills with exactly 4 words, then drains in order.
        add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 16'h0000, 16'hA500);
        add(1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hA500);
        add(1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0000, 16'hA500);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hA500);
        add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hA500);
        add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'hA501);
        add(1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'hA502);
        add(1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 16'h0003, 16'hA503);
        add(1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'hA504);

        lat = 0;
        foreach (vecs[i]) begin
            ir_ready = vecs[i].ready;
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h out=%h",
                         i, mem_req, mem_addr, ir_valid, ir_pc, ir_out);
                chk("vec mem_req", 16'(mem_req), 16'(vecs[i].exp_req));
                if (vecs[i].exp_req) chk("vec mem_addr", mem_addr, vecs[i].exp_addr);
                chk("vec ir_valid", 16'(ir_valid), 16'(vecs[i].exp_valid));
                if (vecs[i].exp_valid) begin
                    chk("vec ir_pc", ir_pc, vecs[i].exp_pc);
                    chk("vec ir_out", ir_out, vecs[i].exp_out);
                end
                step();
            end
        end

        // Redirect during the first wait cycle of the request for 0x0002.
        ir_ready = 1'b1; lat = 3;
        do_reset();
        repeat (9) step();
        chk("t3 pre req", 16'(mem_req), 16'h1);
        chk("t3 pre addr", mem_addr, 16'h0002);
        chk("t3 pre pc", ir_pc, 16'h0001);
        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("t3 flush valid", 16'(ir_valid), 16'h0);
        chk("t3 drop req", 16'(mem_req), 16'h1);
        chk("t3 drop addr", mem_addr, 16'h0002);
        step(); step();
        chk("t3 drop addr hold", mem_addr, 16'h0002);
        step();
        chk("t3 idle req", 16'(mem_req), 16'h0);
        step();
        chk("t3 new req", 16'(mem_req), 16'h1);
        chk("t3 new addr", mem_addr, 16'h0040);
        for (int k = 0; k < 30 && !ir_valid; k++) step();
        chk("t3 valid within budget", 16'(ir_valid), 16'h1);
        chk("t3 first pc", ir_pc, 16'h0040);
        chk("t3 first out", ir_out, 16'hA540);
        $display("redirect drop: pc=%h out=%h", ir_pc, ir_out);

        // Redirect near the top of the address space; fetch_pc wraps.
        ir_ready = 1'b1; lat = 0;
        do_reset();
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("t4 c1 req", 16'(mem_req), 16'h0);
        step();
        chk("t4 c2 req", 16'(mem_req), 16'h1);
        chk("t4 c2 addr", mem_addr, 16'hFFFE);
        step();
        chk("t4 pc0", ir_pc, 16'hFFFE);
        chk("t4 out0", ir_out, 16'h5AFE);
        step();
        chk("t4 pc1", ir_pc, 16'hFFFF);
        chk("t4 out1", ir_out, 16'h5AFF);
        chk("t4 wrap addr", mem_addr, 16'h0000);
        step();
        chk("t4 pc2", ir_pc, 16'h0000);
        chk("t4 out2", ir_out, 16'hA500);
        $display("wrap: pc=%h out=%h", ir_pc, ir_out);

        // Redirect + ack + pop in one cycle with 2 words buffered.
        ir_ready = 1'b0; lat = 0;
        do_reset();
        repeat (3) step();
        chk("t5 pre valid", 16'(ir_valid), 16'h1);
        chk("t5 pre addr", mem_addr, 16'h0002);
        redirect = 1'b1; redirect_pc = 16'h0100; ir_ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("t5 flush valid", 16'(ir_valid), 16'h0);
        chk("t5 idle req", 16'(mem_req), 16'h0);
        step();
        chk("t5 new req", 16'(mem_req), 16'h1);
        chk("t5 new addr", mem_addr, 16'h0100);
        step();
        chk("t5 pc", ir_pc, 16'h0100);
        chk("t5 out", ir_out, 16'hA400);
        $display("redirect+ack+pop: pc=%h out=%h", ir_pc, ir_out);

        // Starvation counter with 5-wait memory.
        ir_ready = 1'b1; lat = 5;
        do_reset();
        repeat (3) step();
        chk("t6 stall c3", stall_count, STALL_EN ? 16'd3 : 16'd0);
        repeat (4) step();
        chk("t6 valid c7", 16'(ir_valid), 16'h1);
        chk("t6 stall c7", stall_count, STALL_EN ? 16'd7 : 16'd0);
        step();
        chk("t6 stall hold c8", stall_count, STALL_EN ? 16'd7 : 16'd0);
        step();
        chk("t6 stall c9", stall_count, STALL_EN ? 16'd8 : 16'd0);
        $display("stall_count=%0d", stall_count);

        // Reset mid-request, then a stray ack while idle must be ignored.
        ir_ready = 1'b0; lat = 3;
        do_reset();
        step(); step();
        chk("t7 mid req", 16'(mem_req), 16'h1);
        do_reset();
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        chk("t7 late ack valid", 16'(ir_valid), 16'h0);
        chk("t7 req", 16'(mem_req), 16'h1);
        chk("t7 addr", mem_addr, 16'h0000);
        step();
        chk("t7 still empty", 16'(ir_valid), 16'h0);
        $display("late ack: valid=%0b", ir_valid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
